test_tone_gen: RTL and testbench

- Stereo test-tone generator for the test-card pattern; feeds the audio output path (I2S/PWM/HDMI audio) as signed PCM at a fixed sample rate.
- DDS phase accumulator per channel indexes a 256-entry sine table. Per-channel frequency, waveform and attenuation are independent.
- Issues a one-cycle sample_valid strobe with each new sample pair.

---
 rtl/test_tone_gen.sv | 217 +++++++++++++++++++++
 tb/tb_test_tone_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_tone_gen.sv
// Stereo DDS test-tone generator: sine/square/sawtooth/mute per channel with arithmetic attenuation.
// Optional channel-ID alternation (one side audible at a time) is built when TONE_ALT_ID_EN is defined.
module test_tone_gen #(
    parameter int CLKMHZ     = 50,
    parameter int FS_HZ      = 48000,
    parameter int DATA_W     = 16,
    parameter int PHASE_W    = 24,
    parameter int ID_SAMPLES = 48000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [PHASE_W-1:0]       phase_inc_l,
    input  logic [PHASE_W-1:0]       phase_inc_r,
    input  logic [1:0]               mode_l,
    input  logic [1:0]               mode_r,
    input  logic [3:0]               atten_l,
    input  logic [3:0]               atten_r,
    output logic signed [DATA_W-1:0] audio_l,
    output logic signed [DATA_W-1:0] audio_r,
    output logic                     sample_valid,
    output logic                     id_side
);

    localparam int TICKS = CLKMHZ * 1000000 / FS_HZ;
    localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS - 1);

    typedef logic signed [DATA_W-1:0] sample_t;
    localparam sample_t AMP = sample_t'((2 ** (DATA_W - 1)) - 1);

    if (DATA_W < 8 || DATA_W > 24 || PHASE_W < DATA_W || TICKS < 2 || ID_SAMPLES < 1) begin : g_bad_params
        $error("test_tone_gen: unsupported parameter set");
    end

    function automatic sample_t sine_val(input int idx);
        real a;
        real x;
        a = real'((2 ** (DATA_W - 1)) - 1);
        x = a * $sin(2.0 * 3.14159265358979323846 * real'(idx) / 256.0);
        return sample_t'((x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x));
    endfunction

    // Constant quarter-free full-cycle sine ROM, folded at elaboration.
    sample_t sine_rom [256];
    for (genvar i = 0; i < 256; i++) begin : g_rom
        assign sine_rom[i] = sine_val(i);
    end

    logic [PHASE_W-1:0] inc [2];
    logic [1:0]         mode_in [2];
    logic [3:0]         atten_in [2];
    assign inc[0]      = phase_inc_l;
    assign inc[1]      = phase_inc_r;
    assign mode_in[0]  = mode_l;
    assign mode_in[1]  = mode_r;
    assign atten_in[0] = atten_l;
    assign atten_in[1] = atten_r;

    logic [CNT_W-1:0]   tick_cnt;
    logic [PHASE_W-1:0] phase_acc [2];
    logic               tick;
    assign tick = enable && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            for (int c = 0; c < 2; c++) phase_acc[c] <= '0;
        end else if (!enable) begin
            tick_cnt <= '0;
            for (int c = 0; c < 2; c++) phase_acc[c] <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                for (int c = 0; c < 2; c++) phase_acc[c] <= phase_acc[c] + inc[c];
            end
        end
    end

    // Only the top DATA_W phase bits matter downstream (table index, square MSB, saw ramp).
    logic [DATA_W-1:0] sp1 [2];
    logic [1:0]        mode1 [2];
    logic [3:0]        atten1 [2];
    logic              v1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                sp1[c]    <= '0;
                mode1[c]  <= '0;
                atten1[c] <= '0;
            end
        end else begin
            v1 <= tick;
            if (tick) begin
                for (int c = 0; c < 2; c++) begin
                    sp1[c]    <= phase_acc[c][PHASE_W-1 -: DATA_W];
                    mode1[c]  <= mode_in[c];
                    atten1[c] <= atten_in[c];
                end
            end
        end
    end

    logic [DATA_W-1:0] sp2 [2];
    logic [1:0]        mode2 [2];
    logic [3:0]        atten2 [2];
    sample_t           sine2 [2];
    logic              v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                sp2[c]    <= '0;
                mode2[c]  <= '0;
                atten2[c] <= '0;
                sine2[c]  <= '0;
            end
        end else begin
            v2 <= v1 && enable;
            for (int c = 0; c < 2; c++) begin
                sp2[c]    <= sp1[c];
                mode2[c]  <= mode1[c];
                atten2[c] <= atten1[c];
                sine2[c]  <= sine_rom[sp1[c][DATA_W-1 -: 8]];
            end
        end
    end

    sample_t wave [2];
    sample_t shaped [2];

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            case (mode2[c])
                2'd0:    wave[c] = sine2[c];
                2'd1:    wave[c] = sp2[c][DATA_W-1] ? -AMP : AMP;
                2'd2:    wave[c] = {~sp2[c][DATA_W-1], sp2[c][DATA_W-2:0]};
                default: wave[c] = '0;
            endcase
            shaped[c] = wave[c] >>> atten2[c];
        end
    end

    logic mute_l;
    logic mute_r;

`ifdef TONE_ALT_ID_EN
    localparam int ID_W = (ID_SAMPLES > 1) ? $clog2(ID_SAMPLES) : 1;
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(ID_SAMPLES - 1);

    logic [ID_W-1:0] id_cnt;
    logic            id_now;
    logic            side1;
    logic            side2;

    // The side is captured with each tick so forcing lines up with the sample it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_cnt <= '0;
            id_now <= 1'b0;
            side1  <= 1'b0;
            side2  <= 1'b0;
        end else if (!enable) begin
            id_cnt <= '0;
            id_now <= 1'b0;
            side1  <= 1'b0;
            side2  <= 1'b0;
        end else begin
            if (tick) begin
                side1 <= id_now;
                if (id_cnt == ID_LAST) begin
                    id_cnt <= '0;
                    id_now <= ~id_now;
                end else begin
                    id_cnt <= id_cnt + 1'b1;
                end
            end
            side2 <= side1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       id_side <= 1'b0;
        else if (!enable) id_side <= 1'b0;
        else if (v2)      id_side <= side2;
    end

    assign mute_l = side2;
    assign mute_r = ~side2;
`else
    assign mute_l  = 1'b0;
    assign mute_r  = 1'b0;
    assign id_side = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_l      <= '0;
            audio_r      <= '0;
            sample_valid <= 1'b0;
        end else if (!enable) begin
            audio_l      <= '0;
            audio_r      <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= v2;
            if (v2) begin
                audio_l <= mute_l ? '0 : shaped[0];
                audio_r <= mute_r ? '0 : shaped[1];
            end
        end
    end

endmodule

// File: tb/tb_test_tone_gen.sv
// Directed bench for test_tone_gen: a fast instance (20-cycle sample period) for waveform checks
// and a default-rate instance (1041-cycle period, ID_SAMPLES = 4) for timing and channel-ID checks.
module tb_test_tone_gen;

`ifdef TONE_ALT_ID_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic [23:0]        phase_inc_l;
    logic [23:0]        phase_inc_r;
    logic [1:0]         mode_l;
    logic [1:0]         mode_r;
    logic [3:0]         atten_l;
    logic [3:0]         atten_r;
    logic signed [15:0] audio_l, audio_r, d_audio_l, d_audio_r;
    logic               sample_valid, id_side, d_sample_valid, d_id_side;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    test_tone_gen #(.CLKMHZ(1), .FS_HZ(48000), .DATA_W(16), .PHASE_W(24), .ID_SAMPLES(48000)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .phase_inc_l(phase_inc_l), .phase_inc_r(phase_inc_r),
        .mode_l(mode_l), .mode_r(mode_r), .atten_l(atten_l), .atten_r(atten_r),
        .audio_l(audio_l), .audio_r(audio_r), .sample_valid(sample_valid), .id_side(id_side)
    );

    test_tone_gen #(.CLKMHZ(50), .FS_HZ(48000), .DATA_W(16), .PHASE_W(24), .ID_SAMPLES(4)) dut_def (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .phase_inc_l(phase_inc_l), .phase_inc_r(phase_inc_r),
        .mode_l(mode_l), .mode_r(mode_r), .atten_l(atten_l), .atten_r(atten_r),
        .audio_l(d_audio_l), .audio_r(d_audio_r), .sample_valid(d_sample_valid), .id_side(d_id_side)
    );

    task automatic next_sample(input bit use_def, input int limit, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        while (!ok && waited < limit) begin
            @(negedge clk);
            waited++;
            ok = use_def ? d_sample_valid : sample_valid;
        end
    endtask

    task automatic restart();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (audio_l !== 16'sd0) begin errors++; $display("[TB] FAIL reset_audio_l: got %0d expected 0", audio_l); end
        checks++; if (audio_r !== 16'sd0) begin errors++; $display("[TB] FAIL reset_audio_r: got %0d expected 0", audio_r); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", sample_valid); end
        checks++; if (id_side !== 1'b0) begin errors++; $display("[TB] FAIL reset_id_side: got %b expected 0", id_side); end
        checks++; if (d_audio_l !== 16'sd0) begin errors++; $display("[TB] FAIL reset_def_audio_l: got %0d expected 0", d_audio_l); end
        checks++; if (d_sample_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_def_valid: got %b expected 0", d_sample_valid); end
    endtask

    task automatic test_tick_timing();
        bit ok;
        int w;
        int exp_w [3] = '{1043, 1040, 1040};
        restart();
        for (int i = 0; i < 3; i++) begin
            next_sample(1'b1, 1200, ok, w);
            checks++;
            if (!ok || w != exp_w[i]) begin
                errors++;
                $display("[TB] FAIL tick_interval[%0d]: got %0d cycles (seen=%0d) expected %0d", i, w, ok, exp_w[i]);
            end
            @(negedge clk);
            checks++;
            if (d_sample_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL valid_width[%0d]: got %b expected 0", i, d_sample_valid);
            end
        end
    endtask

    task automatic test_sine_square();
        bit ok;
        int w;
        int exp_l;
        int exp_r;
        bit chk_l;
        bit chk_r;
        mode_l = 2'd0; atten_l = 4'd0; phase_inc_l = 24'h010000;
        mode_r = 2'd1; atten_r = 4'd0; phase_inc_r = 24'h010000;
        restart();
        for (int s = 0; s <= 256; s++) begin
            next_sample(1'b0, 100, ok, w);
            if (!ok) begin
                errors++; checks++;
                $display("[TB] FAIL sine_timeout: got no strobe at sample %0d expected strobe", s);
                break;
            end
            if (s == 0) begin
                checks++;
                if (w != 22) begin errors++; $display("[TB] FAIL first_latency: got %0d expected 22", w); end
            end
            chk_l = 1'b1;
            case (s)
                0, 128, 256: exp_l = 0;
                32:          exp_l = 23170;
                64:          exp_l = 32767;
                192:         exp_l = -32767;
                default:     chk_l = 1'b0;
            endcase
            if (chk_l) begin
                checks++;
                if (audio_l !== exp_l) begin errors++; $display("[TB] FAIL sine[%0d]: got %0d expected %0d", s, audio_l, exp_l); end
            end
            chk_r = (s == 0 || s == 127 || s == 128 || s == 255);
            exp_r = ID_EN ? 0 : ((s % 256) < 128 ? 32767 : -32767);
            if (chk_r) begin
                checks++;
                if (audio_r !== exp_r) begin errors++; $display("[TB] FAIL square[%0d]: got %0d expected %0d", s, audio_r, exp_r); end
            end
        end
    endtask

    task automatic test_atten_saw();
        bit ok;
        int w;
        int exp_l;
        int exp_r;
        bit chk;
        mode_l = 2'd0; atten_l = 4'd4; phase_inc_l = 24'h010000;
        mode_r = 2'd2; atten_r = 4'd0; phase_inc_r = 24'h010000;
        restart();
        for (int s = 0; s <= 192; s++) begin
            next_sample(1'b0, 100, ok, w);
            if (!ok) begin
                errors++; checks++;
                $display("[TB] FAIL saw_timeout: got no strobe at sample %0d expected strobe", s);
                break;
            end
            chk = 1'b1;
            case (s)
                0:       begin exp_l = 0;     exp_r = -32768; end
                64:      begin exp_l = 2047;  exp_r = -16384; end
                128:     begin exp_l = 0;     exp_r = 0;      end
                192:     begin exp_l = -2048; exp_r = 16384;  end
                default: begin exp_l = 0;     exp_r = 0; chk = 1'b0; end
            endcase
            if (ID_EN) exp_r = 0;
            if (chk) begin
                checks++;
                if (audio_l !== exp_l) begin errors++; $display("[TB] FAIL atten[%0d]: got %0d expected %0d", s, audio_l, exp_l); end
                checks++;
                if (audio_r !== exp_r) begin errors++; $display("[TB] FAIL saw[%0d]: got %0d expected %0d", s, audio_r, exp_r); end
            end
        end
    endtask

    task automatic test_mode_change();
        bit ok;
        int w;
        int exp_l [4] = '{0, 32767, 0, -32767};
        mode_l = 2'd0; atten_l = 4'd0; phase_inc_l = 24'h400000;
        mode_r = 2'd3; atten_r = 4'd0; phase_inc_r = 24'h400000;
        restart();
        for (int s = 0; s < 4; s++) begin
            next_sample(1'b0, 100, ok, w);
            checks++;
            if (!ok || audio_l !== exp_l[s]) begin
                errors++;
                $display("[TB] FAIL mode_change[%0d]: got %0d (seen=%0d) expected %0d", s, audio_l, ok, exp_l[s]);
            end
            checks++;
            if (audio_r !== 16'sd0) begin errors++; $display("[TB] FAIL mute_r[%0d]: got %0d expected 0", s, audio_r); end
            if (s == 1) begin
                repeat (3) @(negedge clk);
                mode_l = 2'd3;
                repeat (2) @(negedge clk);
                checks++;
                if (audio_l !== 16'sd32767) begin errors++; $display("[TB] FAIL hold_mid_period: got %0d expected 32767", audio_l); end
            end
            if (s == 2) begin
                repeat (5) @(negedge clk);
                mode_l = 2'd0;
            end
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int w;
        int seen;
        mode_l = 2'd1; atten_l = 4'd0; phase_inc_l = 24'h010000;
        mode_r = 2'd1; atten_r = 4'd0; phase_inc_r = 24'h010000;
        restart();
        next_sample(1'b0, 100, ok, w);
        checks++;
        if (!ok || audio_l !== 16'sd32767) begin errors++; $display("[TB] FAIL pre_drop: got %0d (seen=%0d) expected 32767", audio_l, ok); end
        // 18 more cycles puts the next tick's sample in its first pipeline stage.
        repeat (18) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (audio_l !== 16'sd0 || audio_r !== 16'sd0) begin
            errors++;
            $display("[TB] FAIL drop_outputs: got l=%0d r=%0d expected 0 0", audio_l, audio_r);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (sample_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("[TB] FAIL drop_no_valid: got %0d strobes expected 0", seen); end
        mode_r = 2'd2;
        enable = 1'b1;
        next_sample(1'b0, 100, ok, w);
        checks++;
        if (!ok || w != 22) begin errors++; $display("[TB] FAIL reenable_latency: got %0d expected 22", w); end
        checks++;
        if (audio_r !== (ID_EN ? 0 : -32768)) begin errors++; $display("[TB] FAIL reenable_phase0_r: got %0d expected %0d", audio_r, ID_EN ? 0 : -32768); end
        checks++;
        if (audio_l !== 16'sd32767) begin errors++; $display("[TB] FAIL reenable_phase0_l: got %0d expected 32767", audio_l); end
    endtask

    task automatic test_reset_midrun();
        bit ok;
        int w;
        mode_l = 2'd1; atten_l = 4'd0; phase_inc_l = 24'h010000;
        mode_r = 2'd2; atten_r = 4'd0; phase_inc_r = 24'h010000;
        restart();
        for (int s = 0; s < 4; s++) next_sample(1'b0, 100, ok, w);
        checks++;
        if (!ok || audio_r !== (ID_EN ? 0 : -32000)) begin
            errors++;
            $display("[TB] FAIL saw_sample3: got %0d (seen=%0d) expected %0d", audio_r, ok, ID_EN ? 0 : -32000);
        end
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (audio_l !== 16'sd0 || audio_r !== 16'sd0 || sample_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got l=%0d r=%0d v=%b expected 0 0 0", audio_l, audio_r, sample_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        next_sample(1'b0, 100, ok, w);
        checks++;
        if (!ok || w != 22) begin errors++; $display("[TB] FAIL post_reset_latency: got %0d expected 22", w); end
        checks++;
        if (audio_r !== (ID_EN ? 0 : -32768)) begin errors++; $display("[TB] FAIL post_reset_phase0: got %0d expected %0d", audio_r, ID_EN ? 0 : -32768); end
    endtask

    task automatic test_id_side();
        bit ok;
        int w;
        int side;
        int exp_l;
        int exp_r;
        mode_l = 2'd1; atten_l = 4'd0; phase_inc_l = 24'h000000;
        mode_r = 2'd1; atten_r = 4'd0; phase_inc_r = 24'h000000;
        restart();
        for (int s = 0; s < 9; s++) begin
            next_sample(1'b1, 1100, ok, w);
            if (!ok) begin
                errors++; checks++;
                $display("[TB] FAIL id_timeout: got no strobe at sample %0d expected strobe", s);
                break;
            end
            side  = ID_EN ? ((s / 4) % 2) : 0;
            exp_l = (side == 1) ? 0 : 32767;
            exp_r = ID_EN ? ((side == 1) ? 32767 : 0) : 32767;
            checks++;
            if (d_id_side !== side[0]) begin errors++; $display("[TB] FAIL id_side[%0d]: got %b expected %0d", s, d_id_side, side); end
            checks++;
            if (d_audio_l !== exp_l) begin errors++; $display("[TB] FAIL id_audio_l[%0d]: got %0d expected %0d", s, d_audio_l, exp_l); end
            checks++;
            if (d_audio_r !== exp_r) begin errors++; $display("[TB] FAIL id_audio_r[%0d]: got %0d expected %0d", s, d_audio_r, exp_r); end
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got no completion expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        phase_inc_l = '0; phase_inc_r = '0;
        mode_l = '0; mode_r = '0;
        atten_l = '0; atten_r = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_tick_timing();
        test_sine_square();
        test_atten_saw();
        test_mode_change();
        test_enable_drop();
        test_reset_midrun();
        test_id_side();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
